// File: rtl/conv_window_fetch_pkg.sv
// Shared widths, FSM encoding and fetch-order helper for the 3x3 window fetcher.
`include "my_header.vh"

package conv_window_fetch_pkg;

    localparam int DW    = `DWIDTH_DAT;
    localparam int NSLOT = `DWSS;
    localparam int AW    = `AWIDTH_FBUFF;
    localparam int KDIM  = `KDIM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    // Full load walks columns 1 then 2 top-to-bottom; incremental load only column 2.
    function automatic logic [3:0] fetch_slot(input logic full, input logic [2:0] step);
        logic [3:0] s;
        if (full) begin
            s = (step < 3'd3) ? 4'(1 + 3 * step) : 4'(2 + 3 * (step - 3'd3));
        end else begin
            s = 4'(2 + 3 * step);
        end
        return s;
    endfunction

endpackage

// File: rtl/my_header.vh
`ifndef MY_HEADER_VH
`define MY_HEADER_VH

`define DWIDTH_DAT   12
`define DWSS         9
`define AWIDTH_FBUFF 15
`define KDIM         3

`endif

// File: rtl/win_addr_gen.sv
// Window position counters plus per-slot pixel address and bounds check.
// Counters move only on advance_i; slot lookups are combinational, no backpressure.
module win_addr_gen
    import conv_window_fetch_pkg::*;
#(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          advance_i,
    input  logic [3:0]    slot_i,
    output logic [AW-1:0] centre_o,
    output logic [AW-1:0] pix_addr_o,
    output logic          pix_inb_o,
    output logic          wrap_o,
    output logic          last_o
);

    logic [AW-1:0] row_q;
    logic [AW-1:0] col_q;
    logic [AW-1:0] addr_q;
    int            slot_r;
    int            slot_c;
    int            pix_r;
    int            pix_c;

    assign wrap_o   = (col_q == AW'(IMG_W - 1));
    assign last_o   = wrap_o && (row_q == AW'(IMG_H - 1));
    assign centre_o = addr_q;

    always_comb begin
        slot_r     = int'(slot_i) / KDIM;
        slot_c     = int'(slot_i) % KDIM;
        pix_r      = int'(row_q) + slot_r - KDIM / 2;
        pix_c      = int'(col_q) + slot_c - KDIM / 2;
        pix_inb_o  = (pix_r >= 0) && (pix_r < IMG_H) && (pix_c >= 0) && (pix_c < IMG_W);
        pix_addr_o = pix_inb_o ? AW'(pix_r * IMG_W + pix_c) : '0;
    end

    // Raster order means the centre address simply counts up, even across a row wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else if (clear_i) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else if (advance_i) begin
            addr_q <= addr_q + AW'(1);
            if (wrap_o) begin
                col_q <= '0;
                row_q <= row_q + AW'(1);
            end else begin
                col_q <= col_q + AW'(1);
            end
        end
    end

endmodule

// File: rtl/conv_window_fetch.sv
// Streams zero-padded 3x3 windows of a frame buffer in raster order.
// First window 8 cycles after start, then 5 (same row) or 8 (new row); holds while out_ready=0.
module conv_window_fetch
    import conv_window_fetch_pkg::*;
#(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                fb_rd_en,
    output logic [AW-1:0]       fb_raddr,
    input  logic [DW-1:0]       fb_rdata,
    output logic [NSLOT*DW-1:0] din,
    output logic [AW-1:0]       raddr_alu,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    state_t        state_q;
    logic [2:0]    step_q;
    logic          full_q;
    logic [DW-1:0] slot_q [NSLOT];
    logic          cap_vld_q;
    logic          cap_zero_q;
    logic [3:0]    cap_slot_q;
    logic          out_valid_q;

    logic [3:0]    cur_slot;
    logic [AW-1:0] pix_addr;
    logic          pix_inb;
    logic          wrap;
    logic          last_win;
    logic          fetch_last;
    logic          start_frame;
    logic          hs;

    assign cur_slot    = fetch_slot(full_q, step_q);
    assign fetch_last  = (step_q == (full_q ? 3'd5 : 3'd2));
    assign start_frame = (state_q == S_IDLE) && start;
    assign hs          = (state_q == S_OUT) && out_valid_q && out_ready;

    win_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_addr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (start_frame),
        .advance_i  (hs && !last_win),
        .slot_i     (cur_slot),
        .centre_o   (raddr_alu),
        .pix_addr_o (pix_addr),
        .pix_inb_o  (pix_inb),
        .wrap_o     (wrap),
        .last_o     (last_win)
    );

    assign fb_rd_en  = (state_q == S_FETCH) && pix_inb;
    assign fb_raddr  = fb_rd_en ? pix_addr : '0;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    always_comb begin
        din = '0;
        for (int i = 0; i < NSLOT; i++) begin
            din[i*DW +: DW] = slot_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            full_q      <= 1'b0;
            cap_vld_q   <= 1'b0;
            cap_zero_q  <= 1'b0;
            cap_slot_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            // Each fetch cycle's slot/zero tag is delayed one cycle to line up with fb_rdata.
            cap_vld_q  <= (state_q == S_FETCH);
            cap_slot_q <= cur_slot;
            cap_zero_q <= !pix_inb;
            if (cap_vld_q) begin
                slot_q[cap_slot_q] <= cap_zero_q ? '0 : fb_rdata;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        step_q  <= '0;
                        full_q  <= 1'b1;
                        for (int r = 0; r < KDIM; r++) begin
                            slot_q[r*KDIM] <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    if (fetch_last) begin
                        state_q <= S_WAIT;
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                S_WAIT: begin
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_win) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_FETCH;
                            step_q  <= '0;
                            full_q  <= wrap;
                            for (int r = 0; r < KDIM; r++) begin
                                if (wrap) begin
                                    slot_q[r*KDIM] <= '0;
                                end else begin
                                    slot_q[r*KDIM]     <= slot_q[r*KDIM + 1];
                                    slot_q[r*KDIM + 1] <= slot_q[r*KDIM + 2];
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Directed/randomized bench for conv_window_fetch on a 4x3 image; memory returns its own address.
module tb_conv_window_fetch;
    import conv_window_fetch_pkg::*;

    localparam int W = 4;
    localparam int H = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                out_ready = 1'b0;
    logic                fb_rd_en;
    logic [AW-1:0]       fb_raddr;
    logic [DW-1:0]       fb_rdata = '0;
    logic [NSLOT*DW-1:0] din;
    logic [AW-1:0]       raddr_alu;
    logic                out_valid;
    logic                busy;
    logic                done;

    int n_vec = 0;
    int n_err = 0;
    int rd_cnt = 0;

    conv_window_fetch #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .fb_rd_en  (fb_rd_en),
        .fb_raddr  (fb_raddr),
        .fb_rdata  (fb_rdata),
        .din       (din),
        .raddr_alu (raddr_alu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fb_rd_en === 1'b1) begin
            fb_rdata <= fb_raddr[DW-1:0];
            rd_cnt   <= rd_cnt + 1;
        end
    end

    function automatic bit inb(input int r, input int c);
        return (r >= 0) && (r < H) && (c >= 0) && (c < W);
    endfunction

    function automatic logic [NSLOT*DW-1:0] exp_win(input int row, input int col);
        logic [NSLOT*DW-1:0] v;
        v = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (inb(row + r - 1, col + c - 1)) begin
                    v[(r*3 + c)*DW +: DW] = DW'((row + r - 1) * W + (col + c - 1));
                end
            end
        end
        return v;
    endfunction

    // Fresh row loads columns 1..2, a step along the row loads only column 2.
    function automatic int exp_reads(input int row, input int col);
        int n;
        n = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = (col == 0) ? 1 : 2; c < 3; c++) begin
                if (inb(row + r - 1, col + c - 1)) n++;
            end
        end
        return n;
    endfunction

    function automatic logic [NSLOT*DW-1:0] pack9(input int v [9]);
        logic [NSLOT*DW-1:0] p;
        p = '0;
        for (int i = 0; i < 9; i++) p[i*DW +: DW] = DW'(v[i]);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"}, fb_rd_en, 0);
        chk({tag, "_raddr"}, fb_raddr, 0);
        chk({tag, "_din"}, din, 0);
        chk({tag, "_raddr_alu"}, raddr_alu, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic run_frame(input bit poke, input int stall_win);
        int lat;
        int n;
        int rd0;
        int row;
        int col;
        int lit [9];
        @(negedge clk);
        start = 1'b1;
        rd0 = rd_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        for (int w = 0; w < W*H; w++) begin
            row = w / W;
            col = w % W;
            lat = 0;
            while (out_valid !== 1'b1 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
                start = poke && (w == 1) && (lat == 2);
            end
            start = 1'b0;
            chk("latency", lat, (col == 0) ? 8 : 5);
            chk("reads", rd_cnt - rd0, exp_reads(row, col));
            chk("din", din, exp_win(row, col));
            chk("raddr_alu", raddr_alu, row*W + col);
            chk("rd_en_out", fb_rd_en, 0);
            if (w == 0) begin
                lit = '{0, 0, 0, 0, 'h000, 'h001, 0, 'h004, 'h005};
                chk("first_win", din, pack9(lit));
                chk("first_reads", rd_cnt - rd0, 4);
            end else if (w == 5) begin
                lit = '{'h000, 'h001, 'h002, 'h004, 'h005, 'h006, 'h008, 'h009, 'h00A};
                chk("mid_win", din, pack9(lit));
            end else if (w == W*H - 1) begin
                lit = '{'h006, 'h007, 0, 'h00A, 'h00B, 0, 0, 0, 0};
                chk("last_win", din, pack9(lit));
                chk("last_addr", raddr_alu, 11);
            end
            n = (w == stall_win) ? 5 : int'($urandom_range(0, 2));
            for (int i = 0; i < n; i++) begin
                @(posedge clk); #1;
                chk("stall_din", din, exp_win(row, col));
                chk("stall_valid", out_valid, 1);
                chk("stall_rd_en", fb_rd_en, 0);
                chk("stall_addr", raddr_alu, row*W + col);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            rd0 = rd_cnt;
            chk("valid_drop", out_valid, 0);
            chk("done", done, (w == W*H - 1));
            if (w == W*H - 1) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                chk("done_pulse", done, 0);
                chk("idle_busy", busy, 0);
                repeat (3) @(posedge clk);
                #1;
                chk("stay_idle", busy, 0);
                chk("no_reads_idle", rd_cnt - rd0, 0);
            end else begin
                chk("busy", busy, 1);
            end
        end
    endtask

    initial begin
        int snap;
        #1;
        chk_zero("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snap = rd_cnt;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_reads", rd_cnt - snap, 0);

        run_frame(1'b0, 5);
        run_frame(1'b1, 2);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_rd_en", fb_rd_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        snap = rd_cnt;
        repeat (5) @(posedge clk);
        #1;
        chk("rel_busy", busy, 0);
        chk("rel_reads", rd_cnt - snap, 0);

        run_frame(1'b0, 11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
